ms_uart_wb_master: RTL and testbench
====================================

Name: ms_uart_wb_master

Overview:
- UART-to-Wishbone debug bridge: the initiator-side counterpart to the UART Wishbone slave wrapper.
- Consumes command bytes from a UART receive FIFO and issues single 32-bit Wishbone master reads/writes.
- Returns responses through a UART transmit FIFO.
- Sits between an ms_uart core (FIFO-side signals) and the system Wishbone interconnect as a bus master.

Parameters:
- BUS_TO, 255: cycles cyc_o/stb_o may wait for ack_i before abort (1..65535).
- BYTE_TO, 1000000: idle cycles allowed between bytes of one frame before frame discard (1..2^24-1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- rx_empty  in  1  UART RX FIFO empty
- rx_rdata  in  8  RX FIFO head byte (show-ahead, valid when rx_empty=0)
- rx_rd  out  1  pop RX FIFO head this cycle
- tx_full  in  1  UART TX FIFO full
- tx_wdata  out  8  byte to push
- tx_wr  out  1  push tx_wdata this cycle
- adr_o  out  32  WB address
- dat_o  out  32  WB write data
- dat_i  in  32  WB read data
- sel_o  out  4  WB byte select, constant 4'hF
- cyc_o  out  1  WB cycle
- stb_o  out  1  WB strobe
- we_o  out  1  WB write enable
- ack_i  in  1  WB acknowledge
- busy  out  1  high whenever state != IDLE

Behaviour:
- One clock domain, clk_i. Reset is synchronous and active-high on rst_i, sampled only at posedge clk_i.
- Reset values: state=IDLE, rx_rd=0, tx_wr=0, cyc_o=0, stb_o=0, we_o=0, adr_o=0, dat_o=0, busy=0.

Frame format, all multi-byte fields MSB first:
- Write: 0x57 'W', A3 A2 A1 A0, D3 D2 D1 D0.
- Read: 0x52 'R', A3 A2 A1 A0.
- Write response: 0x4B 'K'.
- Read response: D3 D2 D1 D0.
- Any bus timeout: single byte 0x45 'E'.

States:
- IDLE
  - If rx_empty=0: pop.
  - 0x57 -> ADDR with we=1.
  - 0x52 -> ADDR with we=0.
  - Any other byte is popped and discarded; stay IDLE.
- ADDR
  - Pop 4 bytes, shifting each into adr_o.
  - After the 4th: write -> DATA; read -> BUS.
- DATA
  - Pop 4 bytes into dat_o, then -> BUS.
- BUS
  - cyc_o=stb_o=1, we_o per command.
  - Bus counter counts from 0 while waiting.
  - ack_i=1 sampled at an edge: cyc_o/stb_o low from that edge on. Read latches dat_i into the response register. -> RESP.
  - Counter reaches BUS_TO with no ack: drop cyc_o/stb_o, load response 'E' (length 1). -> RESP.
  - ack_i and counter==BUS_TO on the same edge: ack wins.
- RESP
  - tx_wdata = current response byte.
  - tx_wr = ~tx_full. One byte per cycle at most; byte advances only on a cycle with tx_wr=1.
  - Response lengths: read-ok 4 bytes, write-ok 1 byte, error 1 byte.
  - After the last byte -> IDLE.

RX handshake and frame timing:
- rx_rd = (state in IDLE/ADDR/DATA) & ~rx_empty. Combinational, at most one pop per cycle.
- The byte is captured on the same edge as the pop. Back-to-back pops are allowed.
- Latency: cyc_o rises on the edge that captures the final frame byte, i.e. asserted the cycle after that pop.

Timeouts:
- Inter-byte timeout:
  - In ADDR/DATA, a counter resets on each pop and increments otherwise.
  - Reaching BYTE_TO -> IDLE with no response and no bus cycle.
  - A pop on the same cycle as expiry: the pop wins.
- Bus timeout:
  - Bus counter is cleared on entry to BUS.
  - Counter width is 16 bits; no wrap.

Other:
- RX is never popped in BUS or RESP; bytes arriving then remain queued for the next frame.
- rst_i asserted in any state:
  - Next edge: IDLE, cyc_o/stb_o=0, partial frame and pending response discarded.
  - No tx_wr or rx_rd during reset cycles.
- adr_o/dat_o are stable for the whole BUS state.

Test Plan:
- Write: RX bytes 57 00 00 10 04 DE AD BE EF, slave acks after 3 cycles -> one WB cycle with adr_o=0x00001004, dat_o=0xDEADBEEF, we_o=1, sel_o=F; cyc_o high exactly until the ack edge; TX gets 4B.
- Read: RX 52 00 00 02 00, slave returns dat_i=0x00000001 with ack -> we_o=0, adr_o=0x00000200; TX gets 00 00 00 01 in order.
- Bus timeout, BUS_TO=8, no ack: RX 52 00 00 00 00 -> cyc_o high for exactly 8 cycles then low; TX gets 45 only; busy falls after the push.
- Garbage and frame timeout, BYTE_TO=20:
  - RX 00 7F -> both popped, no WB cycle.
  - RX 57 00 then a 25-cycle gap then 52 00 00 00 08 -> first frame dropped; a read to 0x8 executes.
- Backpressure: tx_full held high 10 cycles during a read response -> tx_wr stays 0 and no byte is lost; after release the 4 bytes are emitted in order.
- Reset mid-BUS: assert rst_i for 1 cycle while cyc_o=1 -> cyc_o=0 and busy=0 on the next edge; no TX byte is emitted; the next frame works normally.

Source files
------------

// File: rtl/ms_uart_wb_master.sv
// UART-to-Wishbone debug bridge: parses 'W'/'R' frames from a UART RX FIFO, runs one
// 32-bit Wishbone access and streams the response ('K', read data or 'E') into the TX FIFO.
module ms_uart_wb_master #(
  parameter int unsigned BUS_TO  = 255,
  parameter int unsigned BYTE_TO = 1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_empty,
  input  logic [7:0]  rx_rdata,
  output logic        rx_rd,
  input  logic        tx_full,
  output logic [7:0]  tx_wdata,
  output logic        tx_wr,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i,
  output logic        busy
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [7:0]  CMD_WRITE = 8'h57;
  localparam logic [7:0]  CMD_READ  = 8'h52;
  localparam logic [7:0]  RSP_OK    = 8'h4B;
  localparam logic [7:0]  RSP_ERR   = 8'h45;
  // Counters start at 0, so expiry is one below the configured cycle count.
  localparam logic [15:0] BUS_LAST  = 16'(BUS_TO - 32'd1);
  localparam logic [23:0] BYTE_LAST = 24'(BYTE_TO - 32'd1);

  state_t      state_r, state_s;
  logic        we_r;
  logic        cyc_r;
  logic        we_bus_r;
  logic [31:0] adr_r;
  logic [31:0] dat_r;
  logic [31:0] resp_r;
  logic [1:0]  byte_cnt_r;
  logic [23:0] gap_cnt_r;
  logic [15:0] bus_cnt_r;
  logic [2:0]  resp_left_r;
  logic        last_byte_s;
  logic        gap_expired_s;
  logic        bus_expired_s;
  logic        last_resp_s;

  assign last_byte_s   = (byte_cnt_r == 2'd3);
  assign gap_expired_s = (gap_cnt_r == BYTE_LAST) && !rx_rd;
  assign bus_expired_s = (bus_cnt_r == BUS_LAST);
  assign last_resp_s   = (resp_left_r == 3'd1);

  assign adr_o    = adr_r;
  assign dat_o    = dat_r;
  assign cyc_o    = cyc_r;
  assign stb_o    = cyc_r;
  assign we_o     = we_bus_r;
  assign sel_o    = 4'hF;
  assign tx_wdata = resp_r[31:24];
  assign busy     = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (rx_rd && (rx_rdata == CMD_WRITE || rx_rdata == CMD_READ)) state_s = ADDR;
        else state_s = IDLE;
      end
      ADDR: begin
        if (rx_rd && last_byte_s) state_s = we_r ? DATA : BUS;
        else if (gap_expired_s) state_s = IDLE;
        else state_s = ADDR;
      end
      DATA: begin
        if (rx_rd && last_byte_s) state_s = BUS;
        else if (gap_expired_s) state_s = IDLE;
        else state_s = DATA;
      end
      BUS: begin
        if (ack_i || bus_expired_s) state_s = RESP;
        else state_s = BUS;
      end
      RESP: begin
        if (tx_wr && last_resp_s) state_s = IDLE;
        else state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // FIFO handshakes; both are held off while reset is asserted.
  always_comb begin
    rx_rd = 1'b0;
    tx_wr = 1'b0;
    case (state_r)
      IDLE, ADDR, DATA: rx_rd = !rst_i && !rx_empty;
      RESP:             tx_wr = !rst_i && !tx_full;
      default: begin
        rx_rd = 1'b0;
        tx_wr = 1'b0;
      end
    endcase
  end

  // Frame capture, bus cycle and response shift register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_r        <= 1'b0;
      cyc_r       <= 1'b0;
      we_bus_r    <= 1'b0;
      adr_r       <= 32'd0;
      dat_r       <= 32'd0;
      resp_r      <= 32'd0;
      byte_cnt_r  <= 2'd0;
      gap_cnt_r   <= 24'd0;
      bus_cnt_r   <= 16'd0;
      resp_left_r <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          byte_cnt_r <= 2'd0;
          gap_cnt_r  <= 24'd0;
          if (rx_rd && rx_rdata == CMD_WRITE) we_r <= 1'b1;
          else if (rx_rd && rx_rdata == CMD_READ) we_r <= 1'b0;
        end
        ADDR, DATA: begin
          if (rx_rd) begin
            if (state_r == ADDR) adr_r <= {adr_r[23:0], rx_rdata};
            else dat_r <= {dat_r[23:0], rx_rdata};
            byte_cnt_r <= byte_cnt_r + 2'd1;
            gap_cnt_r  <= 24'd0;
            // Final byte of the frame launches the bus cycle on this same edge.
            if (last_byte_s && (state_r == DATA || !we_r)) begin
              cyc_r     <= 1'b1;
              we_bus_r  <= we_r;
              bus_cnt_r <= 16'd0;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r + 24'd1;
          end
        end
        BUS: begin
          if (ack_i) begin
            cyc_r    <= 1'b0;
            we_bus_r <= 1'b0;
            if (we_bus_r) begin
              resp_r      <= {RSP_OK, 24'd0};
              resp_left_r <= 3'd1;
            end else begin
              resp_r      <= dat_i;
              resp_left_r <= 3'd4;
            end
          end else if (bus_expired_s) begin
            cyc_r       <= 1'b0;
            we_bus_r    <= 1'b0;
            resp_r      <= {RSP_ERR, 24'd0};
            resp_left_r <= 3'd1;
          end else begin
            bus_cnt_r <= bus_cnt_r + 16'd1;
          end
        end
        RESP: begin
          if (tx_wr) begin
            resp_r      <= {resp_r[23:0], 8'd0};
            resp_left_r <= resp_left_r - 3'd1;
          end
        end
        default: begin
          cyc_r    <= 1'b0;
          we_bus_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ms_uart_wb_master.sv
// Directed and randomized bench for ms_uart_wb_master: FIFO/slave models around the DUT and a
// frame-level reference model that predicts bus transactions, cycle lengths and TX bytes.
module tb_ms_uart_wb_master;
  localparam int BUS_TO  = 8;
  localparam int BYTE_TO = 20;

  logic        clk;
  logic        rst_i;
  logic        rx_empty;
  logic [7:0]  rx_rdata;
  logic        rx_rd;
  logic        tx_full;
  logic [7:0]  tx_wdata;
  logic        tx_wr;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic        ack_i;
  logic        busy;

  ms_uart_wb_master #(.BUS_TO(BUS_TO), .BYTE_TO(BYTE_TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_empty(rx_empty), .rx_rdata(rx_rdata), .rx_rd(rx_rd),
    .tx_full(tx_full), .tx_wdata(tx_wdata), .tx_wr(tx_wr), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .sel_o(sel_o), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .ack_i(ack_i),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  rx_q[$];
  int          slv_lat_q[$];
  logic [31:0] slv_dat_q[$];
  bit          exp_we[$];
  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];
  int          exp_len[$];
  logic [7:0]  exp_tx[$];
  bit          obs_we[$];
  logic [31:0] obs_adr[$];
  logic [31:0] obs_dat[$];
  logic [31:0] obs_adr_end[$];
  logic [31:0] obs_dat_end[$];
  int          obs_len[$];
  logic [7:0]  obs_tx[$];

  logic        s_rx_rd = 1'b0;
  logic        s_tx_wr = 1'b0;
  logic        s_busy = 1'b0;
  logic        s_cyc = 1'b0;
  logic        cyc_prev = 1'b0;
  int          cyc_len = 0;
  logic [31:0] last_adr = 32'd0;
  logic [31:0] last_dat = 32'd0;
  bit          slv_act = 1'b0;
  int          slv_cnt = 0;
  int          slv_lat = -1;
  logic [31:0] slv_data = 32'd0;
  int          bp_hold = 0;
  bit          bp_arm = 1'b0;
  bit          bp_rand = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic refresh_rx();
    rx_empty = (rx_q.size() == 0);
    rx_rdata = rx_empty ? 8'($urandom) : rx_q[0];
  endtask

  // One clock: sample/monitor on the falling edge, then update FIFO/slave models after the rise.
  task automatic tick();
    @(negedge clk);
    s_rx_rd = rx_rd;
    s_tx_wr = tx_wr;
    s_busy  = busy;
    s_cyc   = cyc_o;
    if (tx_wr) obs_tx.push_back(tx_wdata);
    if (tx_full) check("tx_wr while tx_full", 32'(tx_wr), 32'd0);
    if (rx_rd) check("rx_rd only with data", 32'(rx_q.size() > 0), 32'd1);
    if (rst_i) begin
      check("rx_rd during reset", 32'(rx_rd), 32'd0);
      check("tx_wr during reset", 32'(tx_wr), 32'd0);
    end
    if (cyc_o) begin
      check("stb_o with cyc_o", 32'(stb_o), 32'd1);
      check("sel_o", 32'(sel_o), 32'hF);
      if (!cyc_prev) begin
        obs_we.push_back(we_o);
        obs_adr.push_back(adr_o);
        obs_dat.push_back(dat_o);
        cyc_len = 0;
      end
      cyc_len++;
      last_adr = adr_o;
      last_dat = dat_o;
    end else if (cyc_prev) begin
      obs_len.push_back(cyc_len);
      obs_adr_end.push_back(last_adr);
      obs_dat_end.push_back(last_dat);
    end
    cyc_prev = cyc_o;
    @(posedge clk);
    #1;
    if (s_rx_rd && rx_q.size() > 0) void'(rx_q.pop_front());
    refresh_rx();
    if (cyc_o) begin
      if (!slv_act) begin
        slv_act  = 1'b1;
        slv_cnt  = 0;
        slv_lat  = (slv_lat_q.size() > 0) ? slv_lat_q.pop_front() : -1;
        slv_data = (slv_dat_q.size() > 0) ? slv_dat_q.pop_front() : 32'd0;
      end
      ack_i = (slv_lat >= 0 && slv_cnt == slv_lat);
      dat_i = ack_i ? slv_data : $urandom;
      slv_cnt++;
    end else begin
      if (slv_act && bp_arm) begin
        bp_hold = 10;
        bp_arm  = 1'b0;
      end
      slv_act = 1'b0;
      ack_i   = 1'b0;
      dat_i   = $urandom;
    end
    if (bp_hold > 0) begin
      tx_full = 1'b1;
      bp_hold--;
    end else begin
      tx_full = bp_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  endtask

  // Reference model: a bus access succeeds iff the slave acks within the first BUS_TO cycles.
  function automatic bit acked(input int lat);
    return (lat >= 0) && (lat < BUS_TO);
  endfunction

  task automatic add_write(input logic [31:0] a, input logic [31:0] d, input int lat);
    rx_q.push_back(8'h57);
    for (int i = 3; i >= 0; i--) rx_q.push_back(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) rx_q.push_back(d[i*8 +: 8]);
    refresh_rx();
    slv_lat_q.push_back(lat);
    slv_dat_q.push_back($urandom);
    exp_we.push_back(1'b1);
    exp_adr.push_back(a);
    exp_dat.push_back(d);
    exp_len.push_back(acked(lat) ? lat + 1 : BUS_TO);
    exp_tx.push_back(acked(lat) ? 8'h4B : 8'h45);
  endtask

  task automatic add_read(input logic [31:0] a, input logic [31:0] d, input int lat);
    rx_q.push_back(8'h52);
    for (int i = 3; i >= 0; i--) rx_q.push_back(a[i*8 +: 8]);
    refresh_rx();
    slv_lat_q.push_back(lat);
    slv_dat_q.push_back(d);
    exp_we.push_back(1'b0);
    exp_adr.push_back(a);
    exp_dat.push_back(32'd0);
    exp_len.push_back(acked(lat) ? lat + 1 : BUS_TO);
    if (acked(lat)) begin
      for (int i = 3; i >= 0; i--) exp_tx.push_back(d[i*8 +: 8]);
    end else begin
      exp_tx.push_back(8'h45);
    end
  endtask

  task automatic add_garbage(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
      rx_q.push_back(b);
    end
    refresh_rx();
  endtask

  task automatic drain(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 2 && n < budget) begin
      tick();
      n++;
      if (rx_q.size() == 0 && !s_busy) quiet++;
      else quiet = 0;
    end
    check("drain within cycle budget", 32'(quiet >= 2), 32'd1);
  endtask

  task automatic clear_all();
    exp_we.delete(); exp_adr.delete(); exp_dat.delete(); exp_len.delete(); exp_tx.delete();
    obs_we.delete(); obs_adr.delete(); obs_dat.delete(); obs_adr_end.delete();
    obs_dat_end.delete(); obs_len.delete(); obs_tx.delete();
  endtask

  task automatic compare_batch(input string name);
    check($sformatf("%s txn count", name), 32'(obs_adr.size()), 32'(exp_adr.size()));
    check($sformatf("%s cyc count", name), 32'(obs_len.size()), 32'(exp_len.size()));
    check($sformatf("%s tx count", name), 32'(obs_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_adr.size(); i++) begin
      if (i < obs_adr.size()) begin
        check($sformatf("%s we[%0d]", name, i), 32'(obs_we[i]), 32'(exp_we[i]));
        check($sformatf("%s adr[%0d]", name, i), obs_adr[i], exp_adr[i]);
        if (exp_we[i]) check($sformatf("%s dat[%0d]", name, i), obs_dat[i], exp_dat[i]);
      end
      if (i < obs_len.size()) begin
        check($sformatf("%s cyc_len[%0d]", name, i), 32'(obs_len[i]), 32'(exp_len[i]));
        check($sformatf("%s adr_end[%0d]", name, i), obs_adr_end[i], exp_adr[i]);
        if (exp_we[i]) check($sformatf("%s dat_end[%0d]", name, i), obs_dat_end[i], exp_dat[i]);
      end
    end
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (i < obs_tx.size()) check($sformatf("%s tx[%0d]", name, i), 32'(obs_tx[i]), 32'(exp_tx[i]));
    end
    clear_all();
  endtask

  initial begin
    rst_i = 1'b1; tx_full = 1'b0; dat_i = 32'd0; ack_i = 1'b0;
    refresh_rx();

    // Reset: a queued byte must not be popped while reset is held.
    tick();
    rx_q.push_back(8'h00);
    refresh_rx();
    tick();
    check("reset cyc_o", 32'(cyc_o), 32'd0);
    check("reset stb_o", 32'(stb_o), 32'd0);
    check("reset we_o", 32'(we_o), 32'd0);
    check("reset adr_o", adr_o, 32'd0);
    check("reset dat_o", dat_o, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset byte kept", 32'(rx_q.size()), 32'd1);
    rst_i = 1'b0;
    drain(100);
    compare_batch("post-reset garbage");

    add_write(32'h0000_1004, 32'hDEAD_BEEF, 3);
    drain(200);
    compare_batch("write");

    add_read(32'h0000_0200, 32'h0000_0001, 1);
    drain(200);
    compare_batch("read");

    // Bus timeout: busy must drop the cycle after the single 'E' push.
    add_read(32'h0000_0000, 32'h1234_5678, -1);
    for (int k = 0; k < 100 && !s_tx_wr; k++) tick();
    check("timeout push seen", 32'(s_tx_wr), 32'd1);
    check("busy during E push", 32'(s_busy), 32'd1);
    tick();
    check("busy after E push", 32'(s_busy), 32'd0);
    drain(100);
    compare_batch("bus timeout");

    add_read(32'h0000_0010, 32'h0000_0000, 7);
    drain(200);
    compare_batch("ack on timeout edge");

    rx_q.push_back(8'h00);
    rx_q.push_back(8'h7F);
    refresh_rx();
    drain(100);
    check("garbage popped", 32'(rx_q.size()), 32'd0);
    compare_batch("garbage");

    // Truncated frame followed by a 25-cycle gap is abandoned.
    rx_q.push_back(8'h57);
    rx_q.push_back(8'h00);
    refresh_rx();
    for (int k = 0; k < 25; k++) tick();
    check("frame timeout busy", 32'(s_busy), 32'd0);
    add_read(32'h0000_0008, $urandom, 2);
    drain(200);
    compare_batch("frame timeout");

    bp_arm = 1'b1;
    add_read($urandom, $urandom, 2);
    drain(300);
    compare_batch("backpressure");

    // Reset while the bus cycle is open.
    rx_q.push_back(8'h52);
    rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h00); rx_q.push_back(8'h40);
    refresh_rx();
    slv_lat_q.push_back(-1);
    slv_dat_q.push_back(32'd0);
    for (int k = 0; k < 50 && !s_cyc; k++) tick();
    check("reset test reached bus", 32'(s_cyc), 32'd1);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    check("mid-bus reset cyc_o", 32'(cyc_o), 32'd0);
    check("mid-bus reset stb_o", 32'(stb_o), 32'd0);
    check("mid-bus reset busy", 32'(busy), 32'd0);
    rst_i = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check("mid-bus reset no tx", 32'(obs_tx.size()), 32'd0);
    check("mid-bus reset txn", 32'(obs_adr.size()), 32'd1);
    check("mid-bus reset adr", obs_adr[0], 32'h0000_0040);
    clear_all();
    add_write($urandom, $urandom, 0);
    drain(200);
    compare_batch("after mid-bus reset");

    for (int b = 0; b < 3; b++) begin
      bp_rand = (b == 2);
      for (int f = 0; f < 6; f++) begin
        int lat;
        lat = $urandom_range(0, 10);
        if (lat == 10) lat = -1;
        add_garbage($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 1) add_write($urandom, $urandom, lat);
        else add_read($urandom, $urandom, lat);
      end
      drain(3000);
      compare_batch($sformatf("random batch %0d", b));
    end
    bp_rand = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
